dialysis_supervisor: RTL and testbench
======================================

DIALYSIS_SUPERVISOR -- requirements
Module: dialysis_supervisor

Interface
REQ-001 SHALL have parameter N_WARN, default 4, number of debounced warning channels (range 1..16).
REQ-002 SHALL have parameter N_CRIT, default 3, number of critical channels (range 1..16).
REQ-003 SHALL have parameter DEB_CYC, default 4, consecutive equal samples needed to change a debounced warning (range 1..255).
REQ-004 SHALL have parameter WARN_TIMEOUT, default 64, cycles in WARNING before escalation to EMERGENCY (range 2..65535).
REQ-005 SHALL have parameter PRIME_CYC, default 16, cycles spent in PRIME (range 1..65535).
REQ-006 SHALL have ports, clock and reset first: clk in 1 system clock; reset in 1 asynchronous active-low reset; start_cmd in 1 start request; stop_cmd in 1 orderly stop; ack_cmd in 1 emergency acknowledge; warn_in in N_WARN raw warning flags; crit_in in N_CRIT critical faults; pump_on out 1 blood pump enable; clamp_open out 1 venous clamp open; correct_en out N_WARN per-channel corrective actuator enable; alarm_warning out 1; alarm_emergency out 1; crit_latched out N_CRIT sticky fault record; esc_latched out 1 timeout-escalation record; state_o out 3 encoded state.

Function
REQ-007 SHALL implement states IDLE=0, PRIME=1, NORMAL=2, WARNING=3, EMERGENCY=4; state_o SHALL equal the state register.
REQ-008 SHALL register crit_in once (crit_q); any crit_q bit high SHALL move every state to EMERGENCY at the next edge (EMERGENCY visible 2 edges after crit_in rises).
REQ-009 SHALL set crit_latched[i] on the same edge as entering EMERGENCY for every crit_q[i] high, and OR in further bits while in EMERGENCY.
REQ-010 SHALL debounce each warn_in[i]: warn_db[i] rises after DEB_CYC consecutive high samples and falls after DEB_CYC consecutive low samples; any differing sample restarts the count.
REQ-011 IDLE: start_cmd high -> PRIME; outputs all low.
REQ-012 PRIME: pump_on=1, clamp_open=0; prime counter runs; after PRIME_CYC cycles -> NORMAL; warn_db ignored during PRIME.
REQ-013 NORMAL: pump_on=1, clamp_open=1; any warn_db high -> WARNING.
REQ-014 WARNING: pump_on=1, clamp_open=1, alarm_warning=1, correct_en=warn_db; warn timer increments each cycle; all warn_db low -> NORMAL with timer cleared; timer reaching WARN_TIMEOUT-1 -> EMERGENCY with esc_latched set.
REQ-015 correct_en SHALL be zero in every state except WARNING.
REQ-016 EMERGENCY: pump_on=0, clamp_open=0, alarm_emergency=1; exits to IDLE only when ack_cmd=1 and crit_q all low, clearing crit_latched and esc_latched on that edge; ack_cmd with any crit_q high SHALL be ignored.
REQ-017 stop_cmd in PRIME, NORMAL or WARNING -> IDLE; stop_cmd in EMERGENCY ignored.
REQ-018 Same-cycle priority SHALL be crit_q > timeout escalation > stop_cmd > start_cmd/warning transitions.
REQ-019 Outputs SHALL be decoded from the state register only (Moore), with no combinational path from any input.
REQ-020 Prime and warn counters SHALL saturate, never wrap, and clear on every state exit.

Reset
REQ-021 reset low SHALL asynchronously force IDLE, clear all counters, warn_db, crit_q, crit_latched, esc_latched; all outputs 0.
REQ-022 Reset asserted mid-therapy (any state) SHALL take effect immediately without waiting for a clock edge; release SHALL be synchronised internally to clk.

Structure
REQ-023 State encoding and parameter defaults SHALL live in shared package dialysis_pkg.
REQ-024 Debouncer SHALL be sub-module dialysis_debounce (one instance per warn channel, parameter DEB_CYC).

Verification
REQ-025 Reset, start pulse, 16 cycles -> PRIME then state_o=2, pump_on=1, clamp_open=1.
REQ-026 warn_in=4'b0100 held 3 cycles then dropped -> no WARNING; held 4 cycles -> WARNING, correct_en=4'b0100, alarm_warning=1; released 4 cycles -> NORMAL.
REQ-027 warn_in=4'b0001 held 80 cycles -> EMERGENCY exactly 64 cycles after WARNING entry, esc_latched=1, pump_on=0.
REQ-028 crit_in=3'b010 in NORMAL -> EMERGENCY 2 edges later, crit_latched=3'b010; ack_cmd with crit high -> stays; crit low then ack -> IDLE, latches 0.
REQ-029 stop_cmd and crit_in[0] rise same cycle in WARNING -> EMERGENCY, not IDLE.
REQ-030 reset asserted in EMERGENCY between edges -> all outputs 0 immediately, state_o=0.

Source files
------------

// File: rtl/dialysis_pkg.sv
// Shared state encoding, parameter defaults and counter helpers for the
// dialysis supervisor and its debouncer.
package dialysis_pkg;

  localparam int DEF_N_WARN       = 4;
  localparam int DEF_N_CRIT       = 3;
  localparam int DEF_DEB_CYC      = 4;
  localparam int DEF_WARN_TIMEOUT = 64;
  localparam int DEF_PRIME_CYC    = 16;

  localparam int CNT_W = 16;
  localparam int DEB_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRIME     = 3'd1,
    ST_NORMAL    = 3'd2,
    ST_WARNING   = 3'd3,
    ST_EMERGENCY = 3'd4
  } state_t;

  // Saturating increment: a stuck counter is safer than one that wraps to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dialysis_debounce.sv
// Single-channel debouncer: the output follows the raw input only after
// DEB_CYC consecutive samples disagree with the current debounced value.
module dialysis_debounce
  import dialysis_pkg::*;
#(
  parameter int DEB_CYC = DEF_DEB_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  logic [DEB_W-1:0] cnt;

  // Any sample equal to db breaks the run and restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (raw == db) begin
      cnt <= '0;
    end else if (cnt == DEB_LAST) begin
      db  <= raw;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dialysis_supervisor.sv
// Therapy supervisor FSM: prime, normal run, warning with timed escalation
// and a latched emergency that needs an explicit acknowledge to clear.
module dialysis_supervisor
  import dialysis_pkg::*;
#(
  parameter int N_WARN       = DEF_N_WARN,
  parameter int N_CRIT       = DEF_N_CRIT,
  parameter int DEB_CYC      = DEF_DEB_CYC,
  parameter int WARN_TIMEOUT = DEF_WARN_TIMEOUT,
  parameter int PRIME_CYC    = DEF_PRIME_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_cmd,
  input  logic              stop_cmd,
  input  logic              ack_cmd,
  input  logic [N_WARN-1:0] warn_in,
  input  logic [N_CRIT-1:0] crit_in,
  output logic              pump_on,
  output logic              clamp_open,
  output logic [N_WARN-1:0] correct_en,
  output logic              alarm_warning,
  output logic              alarm_emergency,
  output logic [N_CRIT-1:0] crit_latched,
  output logic              esc_latched,
  output logic [2:0]        state_o
);

  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYC - 1);
  localparam logic [CNT_W-1:0] WARN_LAST  = CNT_W'(WARN_TIMEOUT - 1);

  // Reset asserts asynchronously, releases after two clk edges.
  logic rst_meta, rst_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta <= 1'b0;
      rst_n    <= 1'b0;
    end else begin
      rst_meta <= 1'b1;
      rst_n    <= rst_meta;
    end
  end

  logic [N_WARN-1:0] warn_db;
  for (genvar i = 0; i < N_WARN; i++) begin : g_deb
    dialysis_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (warn_in[i]),
      .db   (warn_db[i])
    );
  end

  // Commands share the critical-fault register stage so a stop and a fault
  // arriving together are arbitrated in the same cycle.
  logic [N_CRIT-1:0] crit_q;
  logic start_q, stop_q, ack_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crit_q  <= '0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      crit_q  <= crit_in;
      start_q <= start_cmd;
      stop_q  <= stop_cmd;
      ack_q   <= ack_cmd;
    end
  end

  state_t           state;
  logic [CNT_W-1:0] prime_cnt, warn_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      prime_cnt    <= '0;
      warn_cnt     <= '0;
      crit_latched <= '0;
      esc_latched  <= 1'b0;
    end else if (|crit_q) begin
      state        <= ST_EMERGENCY;
      crit_latched <= crit_latched | crit_q;
      prime_cnt    <= '0;
      warn_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_q) state <= ST_PRIME;
        end
        ST_PRIME: begin
          if (stop_q) begin
            state     <= ST_IDLE;
            prime_cnt <= '0;
          end else if (prime_cnt == PRIME_LAST) begin
            state     <= ST_NORMAL;
            prime_cnt <= '0;
          end else begin
            prime_cnt <= sat_inc(prime_cnt);
          end
        end
        ST_NORMAL: begin
          if (stop_q)        state <= ST_IDLE;
          else if (|warn_db) state <= ST_WARNING;
        end
        ST_WARNING: begin
          if (warn_cnt == WARN_LAST) begin
            state       <= ST_EMERGENCY;
            esc_latched <= 1'b1;
            warn_cnt    <= '0;
          end else if (stop_q) begin
            state    <= ST_IDLE;
            warn_cnt <= '0;
          end else if (!(|warn_db)) begin
            state    <= ST_NORMAL;
            warn_cnt <= '0;
          end else begin
            warn_cnt <= sat_inc(warn_cnt);
          end
        end
        ST_EMERGENCY: begin
          if (ack_q) begin
            state        <= ST_IDLE;
            crit_latched <= '0;
            esc_latched  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode: outputs depend only on registered state and warn_db.
  assign state_o         = state;
  assign pump_on         = (state == ST_PRIME) || (state == ST_NORMAL) || (state == ST_WARNING);
  assign clamp_open      = (state == ST_NORMAL) || (state == ST_WARNING);
  assign alarm_warning   = (state == ST_WARNING);
  assign alarm_emergency = (state == ST_EMERGENCY);
  assign correct_en      = (state == ST_WARNING) ? warn_db : '0;

endmodule

// File: tb/tb_dialysis_supervisor.sv
// Directed bench for dialysis_supervisor: prime, debounce, warning timeout,
// critical fault latching, stop/fault priority and asynchronous reset.
module tb_dialysis_supervisor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_cmd, stop_cmd, ack_cmd;
  logic [3:0] warn_in;
  logic [2:0] crit_in;
  logic       pump_on, clamp_open, alarm_warning, alarm_emergency, esc_latched;
  logic [3:0] correct_en;
  logic [2:0] crit_latched;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dialysis_supervisor dut (
    .clk            (clk),
    .reset          (reset),
    .start_cmd      (start_cmd),
    .stop_cmd       (stop_cmd),
    .ack_cmd        (ack_cmd),
    .warn_in        (warn_in),
    .crit_in        (crit_in),
    .pump_on        (pump_on),
    .clamp_open     (clamp_open),
    .correct_en     (correct_en),
    .alarm_warning  (alarm_warning),
    .alarm_emergency(alarm_emergency),
    .crit_latched   (crit_latched),
    .esc_latched    (esc_latched),
    .state_o        (state_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [2:0] st, input logic pump,
                            input logic clamp, input logic [3:0] corr);
    check({tag, "_state"}, 32'(state_o), 32'(st));
    check({tag, "_pump"},  32'(pump_on), 32'(pump));
    check({tag, "_clamp"}, 32'(clamp_open), 32'(clamp));
    check({tag, "_corr"},  32'(correct_en), 32'(corr));
  endtask

  // IDLE -> PRIME (command register adds one edge) -> NORMAL after 16 cycles.
  task automatic go_normal(input string tag);
    start_cmd = 1'b1;
    tick(1);
    start_cmd = 1'b0;
    check({tag, "_start_lat"}, 32'(state_o), 32'd0);
    tick(1);
    check_outs({tag, "_prime"}, 3'd1, 1'b1, 1'b0, 4'b0000);
    tick(15);
    check({tag, "_prime_end"}, 32'(state_o), 32'd1);
    tick(1);
    check_outs({tag, "_normal"}, 3'd2, 1'b1, 1'b1, 4'b0000);
  endtask

  initial begin
    reset = 1'b0; start_cmd = 1'b0; stop_cmd = 1'b0; ack_cmd = 1'b0;
    warn_in = '0; crit_in = '0;
    tick(2);
    check_outs("rst", 3'd0, 1'b0, 1'b0, 4'b0000);
    check("rst_alarm_e", 32'(alarm_emergency), 32'd0);
    check("rst_latch", 32'(crit_latched), 32'd0);
    reset = 1'b1;
    tick(3);

    go_normal("a");

    // 3-cycle glitch stays below the debounce threshold.
    warn_in = 4'b0100;
    tick(3);
    warn_in = 4'b0000;
    tick(6);
    check("glitch_state", 32'(state_o), 32'd2);

    warn_in = 4'b0100;
    tick(4);
    check("deb_edge_state", 32'(state_o), 32'd2);
    tick(1);
    check_outs("warn", 3'd3, 1'b1, 1'b1, 4'b0100);
    check("warn_alarm", 32'(alarm_warning), 32'd1);
    warn_in = 4'b0000;
    tick(4);
    check("warn_hold", 32'(state_o), 32'd3);
    tick(1);
    check_outs("back_normal", 3'd2, 1'b1, 1'b1, 4'b0000);

    // Timeout: EMERGENCY exactly 64 edges after WARNING entry.
    warn_in = 4'b0001;
    tick(5);
    check("to_entry", 32'(state_o), 32'd3);
    tick(63);
    check("to_pre", 32'(state_o), 32'd3);
    check("to_pre_esc", 32'(esc_latched), 32'd0);
    tick(1);
    check_outs("to_emerg", 3'd4, 1'b0, 1'b0, 4'b0000);
    check("to_esc", 32'(esc_latched), 32'd1);
    check("to_alarm_e", 32'(alarm_emergency), 32'd1);
    tick(11);
    warn_in = 4'b0000;
    check("to_stay", 32'(state_o), 32'd4);
    ack_cmd = 1'b1;
    tick(2);
    ack_cmd = 1'b0;
    check("to_ack_state", 32'(state_o), 32'd0);
    check("to_ack_esc", 32'(esc_latched), 32'd0);
    tick(6);

    // Critical fault in NORMAL, ack blocked while fault persists.
    go_normal("c");
    crit_in = 3'b010;
    tick(1);
    check("crit_lat1", 32'(state_o), 32'd2);
    tick(1);
    check("crit_emerg", 32'(state_o), 32'd4);
    check("crit_latched", 32'(crit_latched), 32'd2);
    ack_cmd = 1'b1;
    tick(3);
    check("crit_ack_blk", 32'(state_o), 32'd4);
    check("crit_ack_latch", 32'(crit_latched), 32'd2);
    ack_cmd = 1'b0;
    crit_in = 3'b000;
    tick(3);
    check("crit_clear_wait", 32'(state_o), 32'd4);
    ack_cmd = 1'b1;
    tick(2);
    ack_cmd = 1'b0;
    check("crit_ack_state", 32'(state_o), 32'd0);
    check("crit_ack_latch0", 32'(crit_latched), 32'd0);
    tick(2);

    // Stop and critical fault arrive together in WARNING: fault wins.
    go_normal("p");
    warn_in = 4'b0010;
    tick(5);
    check("prio_warn", 32'(state_o), 32'd3);
    stop_cmd = 1'b1;
    crit_in  = 3'b001;
    tick(2);
    stop_cmd = 1'b0;
    check("prio_state", 32'(state_o), 32'd4);
    check("prio_latch", 32'(crit_latched), 32'd1);
    tick(2);
    check("prio_stop_ign", 32'(state_o), 32'd4);

    // Asynchronous reset between edges clears everything at once.
    crit_in = 3'b000;
    warn_in = 4'b0000;
    #2;
    reset = 1'b0;
    #1;
    check_outs("arst", 3'd0, 1'b0, 1'b0, 4'b0000);
    check("arst_alarm_e", 32'(alarm_emergency), 32'd0);
    check("arst_latch", 32'(crit_latched), 32'd0);
    check("arst_esc", 32'(esc_latched), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(3);
    check("post_rst", 32'(state_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
